// File: rtl/numbers_pkg.sv
// Shared types and constants for the seven-segment number renderer:
// seg7 lookup, converter FSM states and default glyph geometry.
package numbers_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  localparam int          DEF_VAL_W   = 14;
  localparam int          DEF_POS_X   = 240;
  localparam int          DEF_POS_Y   = 208;
  localparam int          DEF_DIG_W   = 32;
  localparam int          DEF_DIG_H   = 64;
  localparam int          DEF_DIG_GAP = 8;
  localparam int          DEF_SEG_T   = 6;
  localparam logic [11:0] DEF_FG_RGB  = 12'hFFF;
  localparam logic [11:0] DEF_BG_RGB  = 12'h000;

  // Segment mask per BCD code, bit order {g,f,e,d,c,b,a}; codes 10..15 are dark.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: captures a clamped value on i_start,
// runs one shift per cycle for VAL_W cycles, then holds a one-cycle LOAD state.
module bin2bcd_seq
  import numbers_pkg::*;
#(
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [VAL_W-1:0]  i_value,
  output logic              o_busy,
  output logic              o_ovf,
  output logic [15:0]       o_bcd,
  output conv_state_t       o_state
);

  localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);
  localparam int               CNT_W    = $clog2(VAL_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VAL_W - 1);

  conv_state_t      r_state;
  conv_state_t      w_next;
  logic [VAL_W-1:0] r_shift;
  logic [15:0]      r_bcd;
  logic [15:0]      w_bcd_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // A start outside IDLE is simply not looked at, so a busy converter never restarts.
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = CONV;
      CONV: begin
        o_busy = 1'b1;
        if (r_cnt == LAST_CNT) w_next = LOAD;
      end
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < 4; i++) w_bcd_adj[4*i +: 4] = dd_adjust(r_bcd[4*i +: 4]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_shift <= (i_value > MAX_VAL) ? MAX_VAL : i_value;
      r_ovf   <= (i_value > MAX_VAL);
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else if (r_state == CONV) begin
      r_bcd   <= {w_bcd_adj[14:0], r_shift[VAL_W-1]};
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_ovf   = r_ovf;
  assign o_bcd   = r_bcd;
  assign o_state = r_state;

endmodule

// File: rtl/vga_number_render.sv
// Draws a 4-digit seven-segment number over the VGA pixel stream, one cycle late.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 3 always shown).
module vga_number_render
  import numbers_pkg::*;
#(
  parameter int          VAL_W   = DEF_VAL_W,
  parameter int          POS_X   = DEF_POS_X,
  parameter int          POS_Y   = DEF_POS_Y,
  parameter int          DIG_W   = DEF_DIG_W,
  parameter int          DIG_H   = DEF_DIG_H,
  parameter int          DIG_GAP = DEF_DIG_GAP,
  parameter int          SEG_T   = DEF_SEG_T,
  parameter logic [11:0] FG_RGB  = DEF_FG_RGB,
  parameter logic [11:0] BG_RGB  = DEF_BG_RGB
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [VAL_W-1:0] i_value,
  input  logic             i_animate,
  input  logic             i_active,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic [9:0]       i_x,
  input  logic [8:0]       i_y,
  output logic [11:0]      o_rgb,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_busy,
  output logic             o_ovf
);

  localparam logic [10:0] Y_TOP = 11'(POS_Y);
  localparam logic [10:0] Y_END = 11'(POS_Y + DIG_H);
  localparam logic [10:0] T     = 11'(SEG_T);
  localparam logic [10:0] X_R   = 11'(DIG_W - SEG_T);
  localparam logic [10:0] Y_D   = 11'(DIG_H - SEG_T);
  localparam logic [10:0] HALF  = 11'(DIG_H / 2);
  localparam logic [10:0] G_LO  = 11'(DIG_H / 2 - SEG_T / 2);
  localparam logic [10:0] G_HI  = 11'(DIG_H / 2 + SEG_T / 2);

  logic [15:0]  w_bcd;
  conv_state_t  w_conv_state;
  logic [15:0]  r_digits;
  logic [10:0]  w_x;
  logic [10:0]  w_y;
  logic [3:0]   w_hit;
  logic [11:0]  r_rgb;
  logic         r_hs;
  logic         r_vs;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_animate),
    .i_value (i_value),
    .o_busy  (o_busy),
    .o_ovf   (o_ovf),
    .o_bcd   (w_bcd),
    .o_state (w_conv_state)
  );

  // Digits only move on the LOAD cycle, which falls inside vertical blanking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_digits <= '0;
    else if (w_conv_state == LOAD) r_digits <= w_bcd;
  end

  function automatic logic seg_hit(input logic [10:0] lx, input logic [10:0] ly,
                                   input logic [6:0] m);
    logic left, right, top;
    left  = (lx < T);
    right = (lx >= X_R);
    top   = (ly < HALF);
    return (m[0] && ly < T)           || (m[1] && right && top) ||
           (m[2] && right && !top)    || (m[3] && ly >= Y_D)    ||
           (m[4] && left && !top)     || (m[5] && left && top)  ||
           (m[6] && ly >= G_LO && ly < G_HI);
  endfunction

  assign w_x = {1'b0, i_x};
  assign w_y = {2'b0, i_y};

  for (genvar k = 0; k < 4; k++) begin : g_dig
    localparam logic [10:0] X_LEFT = 11'(POS_X + k * (DIG_W + DIG_GAP));
    localparam logic [10:0] X_END  = 11'(POS_X + k * (DIG_W + DIG_GAP) + DIG_W);
    logic [10:0] w_lx;
    logic [10:0] w_ly;
    logic [3:0]  w_nib;
    logic        w_in_box;
    logic        w_show;

    assign w_lx     = w_x - X_LEFT;
    assign w_ly     = w_y - Y_TOP;
    assign w_nib    = r_digits[(3-k)*4 +: 4];
    assign w_in_box = (w_x >= X_LEFT) && (w_x < X_END) && (w_y >= Y_TOP) && (w_y < Y_END);
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is leading-zero blank when it and every more significant digit are 0.
    if (k == 3) begin : g_last
      assign w_show = 1'b1;
    end else begin : g_lead
      assign w_show = |r_digits[15 -: 4*(k+1)];
    end
`else
    assign w_show = 1'b1;
`endif
    assign w_hit[k] = w_in_box && w_show && seg_hit(w_lx, w_ly, SEG7_LUT[w_nib]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_hs  <= i_hs;
      r_vs  <= i_vs;
      r_rgb <= !i_active ? 12'h000 : ((|w_hit) ? FG_RGB : BG_RGB);
    end
  end

  assign o_rgb = r_rgb;
  assign o_hs  = r_hs;
  assign o_vs  = r_vs;

endmodule
